// File: rtl/pe_array_pkg.sv
// Shared types and constants for the PE array result path.
// Used by pe_result_collector and its optional saturator.
package pe_array_pkg;
  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } col_state_t;

  localparam int RES_W_DEF   = 65;
  localparam int SAT_W       = 32;
  localparam logic [SAT_W-1:0] SAT_LIMIT = 32'hFFFF_FFFF;
  localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/pe_result_sat.sv
// Combinational saturator: clamps a RES_W result to 32 bits and flags the clamp.
module pe_result_sat
  import pe_array_pkg::*;
#(
  parameter int RES_W = RES_W_DEF
) (
  input  logic [RES_W-1:0] din,
  output logic [SAT_W-1:0] dout,
  output logic             sat
);
  assign sat  = |din[RES_W-1:SAT_W];
  assign dout = sat ? SAT_LIMIT : din[SAT_W-1:0];
endmodule

// File: rtl/pe_result_collector.sv
// Gathers one result per PE, then drains them in index order over valid/ready.
// Optional COLLECTOR_SAT32_EN narrows m_data to 32 bits with saturation and adds m_sat.
module pe_result_collector
  import pe_array_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int RES_W  = RES_W_DEF,
  parameter int IDX_W  = $clog2(NUM_PE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PE*RES_W-1:0] pe_result_bus,
  input  logic [NUM_PE-1:0]       done_pe_vec,
`ifdef COLLECTOR_SAT32_EN
  output logic [SAT_W-1:0]        m_data,
  output logic                    m_sat,
`else
  output logic [RES_W-1:0]        m_data,
`endif
  output logic [IDX_W-1:0]        m_idx,
  output logic                    m_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    busy,
  output logic [FRAME_CNT_W-1:0]  frame_cnt,
  output logic                    err_overrun,
  output logic                    err_dup,
  input  logic                    clear_err
);
`ifdef COLLECTOR_SAT32_EN
  localparam int OUT_W = SAT_W;
`else
  localparam int OUT_W = RES_W;
`endif

  col_state_t                   state;
  logic [NUM_PE-1:0]            mask;
  logic [NUM_PE-1:0][RES_W-1:0] res_buf;
  logic [IDX_W-1:0]             rd_ptr;
  logic [IDX_W-1:0]             nxt_ptr;
  logic                         all_done;
  logic                         xfer;
  logic [RES_W-1:0]             ld_val;
  logic [OUT_W-1:0]             out_val;
  logic                         out_sat;

  assign all_done = &(mask | done_pe_vec);
  assign xfer     = m_valid & m_ready;
  assign nxt_ptr  = rd_ptr + IDX_W'(1);
  assign m_idx    = rd_ptr;

  // Entry to be presented next: slot 0 (possibly arriving this very cycle) on
  // frame completion, otherwise the entry after the one being transferred.
  always_comb begin
    ld_val = res_buf[0];
    if (state == COLLECT) begin
      if (done_pe_vec[0]) ld_val = pe_result_bus[0 +: RES_W];
    end else begin
      ld_val = res_buf[nxt_ptr];
    end
  end

`ifdef COLLECTOR_SAT32_EN
  pe_result_sat #(.RES_W(RES_W)) u_sat (
    .din  (ld_val),
    .dout (out_val),
    .sat  (out_sat)
  );
`else
  assign out_val = ld_val;
  assign out_sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= COLLECT;
      mask        <= '0;
      res_buf     <= '0;
      rd_ptr      <= '0;
      m_data      <= '0;
      m_last      <= 1'b0;
      m_valid     <= 1'b0;
      busy        <= 1'b0;
      frame_cnt   <= '0;
      err_overrun <= 1'b0;
      err_dup     <= 1'b0;
`ifdef COLLECTOR_SAT32_EN
      m_sat       <= 1'b0;
`endif
    end else begin
      // Clear first so a same-cycle error event below takes priority.
      if (clear_err) begin
        err_overrun <= 1'b0;
        err_dup     <= 1'b0;
      end
      case (state)
        COLLECT: begin
          for (int i = 0; i < NUM_PE; i++) begin
            if (done_pe_vec[i]) begin
              res_buf[i] <= pe_result_bus[i*RES_W +: RES_W];
              if (mask[i]) err_dup <= 1'b1;
            end
          end
          if (all_done) begin
            mask      <= '0;
            frame_cnt <= frame_cnt + 1'b1;
            state     <= DRAIN;
            busy      <= 1'b1;
            m_valid   <= 1'b1;
            rd_ptr    <= '0;
            m_last    <= 1'b0;
            m_data    <= out_val;
`ifdef COLLECTOR_SAT32_EN
            m_sat     <= out_sat;
`endif
          end else begin
            mask <= mask | done_pe_vec;
          end
        end
        DRAIN: begin
          // Late results are dropped; the frame in flight is untouched.
          if (|done_pe_vec) err_overrun <= 1'b1;
          if (xfer) begin
            if (m_last) begin
              state   <= COLLECT;
              busy    <= 1'b0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              rd_ptr  <= '0;
              m_data  <= '0;
`ifdef COLLECTOR_SAT32_EN
              m_sat   <= 1'b0;
`endif
            end else begin
              rd_ptr <= nxt_ptr;
              m_last <= (nxt_ptr == IDX_W'(NUM_PE-1));
              m_data <= out_val;
`ifdef COLLECTOR_SAT32_EN
              m_sat  <= out_sat;
`endif
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = out_sat;
endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector: frame-level reference model feeds an
// expected-beat queue; an independent monitor checks every presented beat.
module tb_pe_result_collector;
  localparam int NUM_PE = 4;
  localparam int RES_W  = 65;
  localparam int IDX_W  = 2;
`ifdef COLLECTOR_SAT32_EN
  localparam int OUT_W = 32;
`else
  localparam int OUT_W = RES_W;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic [NUM_PE*RES_W-1:0] pe_result_bus = '0;
  logic [NUM_PE-1:0]       done_pe_vec = '0;
  logic [OUT_W-1:0]        m_data;
  logic [IDX_W-1:0]        m_idx;
  logic                    m_last, m_valid, busy, err_overrun, err_dup;
  logic                    m_ready = 1'b0;
  logic                    clear_err = 1'b0;
  logic [15:0]             frame_cnt;
`ifdef COLLECTOR_SAT32_EN
  logic                    m_sat;
`endif

  pe_result_collector #(.NUM_PE(NUM_PE), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .pe_result_bus(pe_result_bus), .done_pe_vec(done_pe_vec),
    .m_data(m_data),
`ifdef COLLECTOR_SAT32_EN
    .m_sat(m_sat),
`endif
    .m_idx(m_idx), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt), .err_overrun(err_overrun),
    .err_dup(err_dup), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               idx;
    logic             last;
    logic             sat;
  } beat_t;

  beat_t       sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [RES_W-1:0] mval [NUM_PE];
  bit          mmask [NUM_PE];
  int          beats_left = 0;
  logic [15:0] exp_frame = 0;
  bit          exp_dup = 0, exp_ovr = 0;

  task automatic chk(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic beat_t mk_beat(input logic [RES_W-1:0] v, input int i);
    beat_t b;
    b.idx  = i;
    b.last = (i == NUM_PE-1);
`ifdef COLLECTOR_SAT32_EN
    b.sat  = (v >> 32) != 0;
    b.data = b.sat ? 32'hFFFF_FFFF : v[31:0];
`else
    b.sat  = 1'b0;
    b.data = v;
`endif
    return b;
  endfunction

  task automatic model_reset();
    sbq.delete();
    for (int i = 0; i < NUM_PE; i++) begin mval[i] = '0; mmask[i] = 0; end
    beats_left = 0; exp_frame = 0; exp_dup = 0; exp_ovr = 0;
  endtask

  // Frame-level rules: a PE row is complete once every PE has reported; the
  // frame then occupies the stream for NUM_PE accepted beats.
  task automatic model_step();
    bit dup_ev, ovr_ev, full;
    dup_ev = 0; ovr_ev = 0;
    if (!rst) return;
    if (beats_left > 0) begin
      if (done_pe_vec != 0) ovr_ev = 1;
      if (m_ready) beats_left--;
    end else begin
      for (int i = 0; i < NUM_PE; i++)
        if (done_pe_vec[i]) begin
          if (mmask[i]) dup_ev = 1;
          mval[i]  = pe_result_bus[i*RES_W +: RES_W];
          mmask[i] = 1;
        end
      full = 1;
      for (int i = 0; i < NUM_PE; i++) if (!mmask[i]) full = 0;
      if (full) begin
        for (int i = 0; i < NUM_PE; i++) begin sbq.push_back(mk_beat(mval[i], i)); mmask[i] = 0; end
        beats_left = NUM_PE;
        exp_frame++;
      end
    end
    exp_dup = (exp_dup && !clear_err) || dup_ev;
    exp_ovr = (exp_ovr && !clear_err) || ovr_ev;
  endtask

  // One clock: drive inputs, let the edge happen, advance the model.
  task automatic cyc(input logic [NUM_PE-1:0] d, input logic [RES_W-1:0] v [NUM_PE],
                     input logic rdy, input logic clr);
    done_pe_vec = d;
    for (int i = 0; i < NUM_PE; i++) pe_result_bus[i*RES_W +: RES_W] = v[i];
    m_ready   = rdy;
    clear_err = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    logic [RES_W-1:0] z [NUM_PE];
    for (int i = 0; i < NUM_PE; i++) z[i] = '0;
    for (int k = 0; k < n; k++) cyc('0, z, rdy, 1'b0);
  endtask

  // Monitor: stream and status checks on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("m_valid", m_valid, beats_left > 0);
      chk("busy", busy, beats_left > 0);
      chk("frame_cnt", frame_cnt, exp_frame);
      chk("err_dup", err_dup, exp_dup);
      chk("err_overrun", err_overrun, exp_ovr);
      if (m_valid) begin
        if (sbq.size() == 0) begin
          errors++; checks++;
          $display("FAIL beat_unexpected: idx=%0d data=%0h with empty queue", m_idx, m_data);
        end else begin
          chk("m_data", m_data, sbq[0].data);
          chk("m_idx", m_idx, sbq[0].idx);
          chk("m_last", m_last, sbq[0].last);
`ifdef COLLECTOR_SAT32_EN
          chk("m_sat", m_sat, sbq[0].sat);
`endif
          if (m_ready) void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [RES_W-1:0] v [NUM_PE];
    logic [RES_W-1:0] z [NUM_PE];
    logic [NUM_PE-1:0] d;
    for (int i = 0; i < NUM_PE; i++) z[i] = '0;
    model_reset();
    #12;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2, 1'b1);

    // Separate-cycle completion, results 10..40.
    for (int i = 0; i < NUM_PE; i++) v[i] = RES_W'(10 * (i + 1));
    for (int i = 0; i < NUM_PE; i++) cyc(NUM_PE'(1) << i, v, 1'b1, 1'b0);
    idle(6, 1'b1);

    // All PEs in one cycle.
    for (int i = 0; i < NUM_PE; i++) v[i] = RES_W'(i + 1);
    cyc('1, v, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Backpressure on beat idx1.
    for (int i = 0; i < NUM_PE; i++) v[i] = RES_W'(10 * (i + 1));
    cyc('1, v, 1'b1, 1'b0);
    idle(1, 1'b1);
    idle(5, 1'b0);
    idle(6, 1'b1);

    // Duplicate done from PE2, then clear.
    v[0] = 100; v[1] = 101; v[2] = 5; v[3] = 103;
    cyc(4'b0011, v, 1'b1, 1'b0);
    cyc(4'b0100, v, 1'b1, 1'b0);
    v[2] = 7;
    cyc(4'b0100, v, 1'b1, 1'b0);
    cyc(4'b1000, v, 1'b1, 1'b0);
    idle(6, 1'b1);
    cyc('0, z, 1'b1, 1'b1);
    idle(1, 1'b1);

    // Overrun: PE0 pulses during drain; next frame needs a fresh PE0.
    for (int i = 0; i < NUM_PE; i++) v[i] = RES_W'(200 + i);
    cyc('1, v, 1'b0, 1'b0);
    v[0] = 999;
    cyc(4'b0001, v, 1'b1, 1'b0);
    idle(6, 1'b1);
    for (int i = 0; i < NUM_PE; i++) v[i] = RES_W'(300 + i);
    cyc(4'b1110, v, 1'b1, 1'b0);
    idle(2, 1'b1);
    cyc(4'b0001, v, 1'b1, 1'b0);
    idle(6, 1'b1);
    cyc('0, z, 1'b1, 1'b1);

    // Saturation boundary values.
    v[0] = 65'h1_0000_0005; v[1] = 65'h0_1234_5678; v[2] = 65'h0_FFFF_FFFF; v[3] = 65'h1_0000_0000;
    cyc('1, v, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Reset mid-drain after beat idx1.
    for (int i = 0; i < NUM_PE; i++) v[i] = RES_W'(50 + i);
    cyc('1, v, 1'b1, 1'b0);
    idle(2, 1'b1);
    rst = 1'b0;
    model_reset();
    #2;
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_m_data", m_data, '0);
    chk("mid_rst_m_idx", m_idx, '0);
    chk("mid_rst_m_last", m_last, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_frame_cnt", frame_cnt, 16'd0);
    idle(2, 1'b1);
    rst = 1'b1;
    idle(1, 1'b1);
    for (int i = 0; i < NUM_PE; i++) v[i] = RES_W'(60 + i);
    for (int i = 0; i < NUM_PE; i++) cyc(NUM_PE'(1) << i, v, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NUM_PE; i++)
        v[i] = {RES_W'($urandom_range(0, 1)), $urandom(), $urandom()};
      for (int i = 0; i < NUM_PE; i++) d[i] = ($urandom_range(0, 3) == 0);
      cyc(d, v, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    idle(12, 1'b1);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_complete: actual=%0d pending beats required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
